// File: rtl/xsleenacore_pkg.sv
// Shared types and sizes for the sprite line buffer.
package xsleenacore_pkg;

  localparam int unsigned OBJ_CW = 7;
  localparam int unsigned OBJ_XW = 8;

  typedef enum logic [1:0] {
    RS_INIT,
    RS_IDLE,
    RS_CHK
  } obj_lb_state_t;

endpackage

// File: rtl/SRAM_dual_sync.sv
// Dual-port synchronous RAM, one-clk read latency on both ports, no reset or init contents.
module SRAM_dual_sync #(
  parameter int unsigned DATA_WIDTH = 7,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  we0,
  input  logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] q0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] q1
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Callers guarantee the two ports never write the same address in one clk.
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= d0;
    if (we1) mem[addr1] <= d1;
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/xsleenacore_obj_linebuffer.sv
// Ping-pong sprite line buffer: renderer fills the back bank with first-opaque-wins
// writes while the front bank is read out and erased pixel by pixel for the mixer.
module xsleenacore_obj_linebuffer
  import xsleenacore_pkg::*;
#(
  parameter int unsigned XW = OBJ_XW,
  parameter int unsigned CW = OBJ_CW
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          HCLKn,
  input  logic          LINE_SWAP,
  input  logic          DISP_EN,
  input  logic          HFLIP,
  input  logic          OBJ_VALID,
  output logic          OBJ_RDY,
  input  logic [XW-1:0] OBJ_X,
  input  logic [CW-1:0] OBJ_COL,
  output logic [CW-1:0] OBJCOL
);

  localparam int unsigned AW = XW + 1;

  obj_lb_state_t state, state_nx;
  logic [AW-1:0] init_addr;
  logic [XW-1:0] x_r;
  logic [CW-1:0] col_r;
  logic          wbank;
  logic          accept;

  logic          bank;
  logic [XW-1:0] cnt;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  logic          rd_req;
  logic [XW-1:0] rd_col;

  logic [AW-1:0] p0_addr, p1_addr;
  logic          p0_we, p1_we;
  logic [CW-1:0] p0_d, q0, q1;
  logic          stored_opaque;

  // Only the low nibble (palette index) decides transparency.
  assign stored_opaque = (q0 & CW'(4'hF)) != '0;

  // Render FSM: next state and port0 control.
  always_comb begin
    state_nx = state;
    p0_addr  = {~bank, OBJ_X};
    p0_we    = 1'b0;
    p0_d     = '0;
    accept   = 1'b0;
    case (state)
      RS_INIT: begin
        p0_addr = init_addr;
        p0_we   = 1'b1;
        if (&init_addr) state_nx = RS_IDLE;
      end
      RS_IDLE: begin
        if (OBJ_VALID && OBJ_RDY) begin
          accept   = 1'b1;
          state_nx = RS_CHK;
        end
      end
      RS_CHK: begin
        p0_addr = {wbank, x_r};
        if (!stored_opaque && (col_r[3:0] != 4'h0)) begin
          p0_we = 1'b1;
          p0_d  = col_r;
        end
        state_nx = RS_IDLE;
      end
      default: state_nx = RS_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state     <= RS_INIT;
      init_addr <= '0;
      OBJ_RDY   <= 1'b0;
      x_r       <= '0;
      col_r     <= '0;
      wbank     <= 1'b0;
    end else begin
      state   <= state_nx;
      OBJ_RDY <= (state_nx == RS_IDLE);
      if (state == RS_INIT) init_addr <= init_addr + AW'(1);
      if (accept) begin
        x_r   <= OBJ_X;
        col_r <= OBJ_COL;
        wbank <= ~bank;
      end
    end
  end

  // Display side: read on the pixel strobe, erase the same address one clk later.
  assign rd_req  = HCLKn && DISP_EN;
  assign rd_col  = HFLIP ? ~cnt : cnt;
  assign p1_addr = rd_pend ? rd_addr : {bank, rd_col};
  assign p1_we   = rd_pend;

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      bank    <= 1'b0;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_addr <= '0;
      OBJCOL  <= '0;
    end else begin
      rd_pend <= rd_req;
      if (rd_req) rd_addr <= {bank, rd_col};
      if (rd_pend) OBJCOL <= q1;
      else if (HCLKn && !DISP_EN) OBJCOL <= '0;
      // A swap restarts the line even if an erase is completing this clk.
      if (LINE_SWAP) begin
        bank <= ~bank;
        cnt  <= '0;
      end else if (rd_pend) begin
        cnt <= cnt + XW'(1);
      end
    end
  end

  SRAM_dual_sync #(
    .DATA_WIDTH(CW),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clk  (clk),
    .addr0(p0_addr),
    .we0  (p0_we),
    .d0   (p0_d),
    .q0   (q0),
    .addr1(p1_addr),
    .we1  (p1_we),
    .d1   ('0),
    .q1   (q1)
  );

endmodule

// File: tb/tb_xsleenacore_obj_linebuffer.sv
// Bench for the sprite line buffer: two-bank array model checked against OBJCOL every clk.
module tb_xsleenacore_obj_linebuffer;

  localparam int XW   = 8;
  localparam int CW   = 7;
  localparam int NPIX = 256;

  logic          clk;
  logic          RSTn, HCLKn, LINE_SWAP, DISP_EN, HFLIP, OBJ_VALID;
  logic          OBJ_RDY;
  logic [XW-1:0] OBJ_X;
  logic [CW-1:0] OBJ_COL;
  logic [CW-1:0] OBJCOL;

  xsleenacore_obj_linebuffer dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .HCLKn    (HCLKn),
    .LINE_SWAP(LINE_SWAP),
    .DISP_EN  (DISP_EN),
    .HFLIP    (HFLIP),
    .OBJ_VALID(OBJ_VALID),
    .OBJ_RDY  (OBJ_RDY),
    .OBJ_X    (OBJ_X),
    .OBJ_COL  (OBJ_COL),
    .OBJCOL   (OBJCOL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: two line arrays, which one is shown, and the pixel position in the line.
  logic [CW-1:0] mdl [2][NPIX];
  logic [CW-1:0] seen [NPIX];
  logic [CW-1:0] exp_objcol;
  int            mbank, mcnt;

  int    checks, failures;
  logic  chk_en, lit_req;
  int    lit_act, lit_exp;
  string lit_name;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (OBJCOL !== exp_objcol) begin
        failures++;
        $display("FAIL objcol t=%0t got=%h want=%h", $time, OBJCOL, exp_objcol);
      end
    end
    if (lit_req) begin
      checks++;
      if (lit_act != lit_exp) begin
        failures++;
        $display("FAIL %s got=%0h want=%0h", lit_name, lit_act, lit_exp);
      end
    end
  end

  task automatic lit_check(input string nm, input int act, input int ex);
    lit_name = nm;
    lit_act  = act;
    lit_exp  = ex;
    lit_req  = 1'b1;
    @(negedge clk);
    #1;
    lit_req = 1'b0;
  endtask

  task automatic swap();
    @(posedge clk); #1;
    LINE_SWAP = 1'b1;
    @(posedge clk); #1;
    LINE_SWAP = 1'b0;
    mbank = 1 - mbank;
    mcnt  = 0;
  endtask

  // One pixel strobe; disp=0 models a strobe outside the active window.
  task automatic pixel(input bit disp);
    int a;
    logic [CW-1:0] v;
    v = '0;
    @(posedge clk); #1;
    HCLKn   = 1'b1;
    DISP_EN = disp;
    if (disp) begin
      a = HFLIP ? (NPIX - 1 - mcnt) : mcnt;
      v = mdl[mbank][a];
      mdl[mbank][a] = '0;
    end
    @(posedge clk); #1;
    HCLKn = 1'b0;
    if (!disp) exp_objcol = '0;
    @(posedge clk); #1;
    if (disp) begin
      exp_objcol = v;
      seen[mcnt] = OBJCOL;
      mcnt = (mcnt + 1) % NPIX;
    end
  endtask

  task automatic scan();
    for (int i = 0; i < NPIX; i++) pixel(1'b1);
  endtask

  // Renderer write; with swap_in_chk the swap lands on the clk the write is checked.
  task automatic wr(input int x, input logic [CW-1:0] col, input bit swap_in_chk);
    int n;
    int wb;
    logic [CW-1:0] cur;
    n = 0;
    @(posedge clk); #1;
    while (!OBJ_RDY && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!OBJ_RDY) lit_check("rdy_timeout", 0, 1);
    OBJ_X     = XW'(x);
    OBJ_COL   = col;
    OBJ_VALID = 1'b1;
    wb  = 1 - mbank;
    cur = mdl[wb][x];
    if (cur[3:0] == 4'h0 && col[3:0] != 4'h0) mdl[wb][x] = col;
    @(posedge clk); #1;
    OBJ_VALID = 1'b0;
    if (swap_in_chk) begin
      LINE_SWAP = 1'b1;
      @(posedge clk); #1;
      LINE_SWAP = 1'b0;
      mbank = 1 - mbank;
      mcnt  = 0;
    end
  endtask

  initial begin
    int n;
    RSTn = 1'b0; HCLKn = 1'b0; LINE_SWAP = 1'b0; DISP_EN = 1'b0; HFLIP = 1'b0;
    OBJ_VALID = 1'b0; OBJ_X = '0; OBJ_COL = '0;
    chk_en = 1'b0; lit_req = 1'b0; lit_act = 0; lit_exp = 0; lit_name = "";
    checks = 0; failures = 0;
    exp_objcol = '0; mbank = 0; mcnt = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NPIX; i++) mdl[b][i] = '0;
    for (int i = 0; i < NPIX; i++) seen[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    lit_check("rdy_in_reset", int'(OBJ_RDY), 0);

    // Clear sequence length
    @(posedge clk); #1;
    RSTn = 1'b1;
    n = 0;
    while (!OBJ_RDY && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    lit_check("init_clks", n, 512);

    // Both banks cleared
    scan();
    swap();
    scan();

    // First opaque pixel wins
    wr(10, 7'h25, 1'b0);
    wr(10, 7'h13, 1'b0);
    swap();
    scan();
    lit_check("first_wins_px10", int'(seen[10]), 'h25);
    lit_check("first_wins_px11", int'(seen[11]), 0);

    // Transparent write discarded
    wr(5, 7'h30, 1'b0);
    wr(6, 7'h0A, 1'b0);
    swap();
    scan();
    lit_check("transparent_px5", int'(seen[5]), 0);
    lit_check("opaque_px6", int'(seen[6]), 'h0A);

    // Erase on read
    wr(20, 7'h11, 1'b0);
    swap();
    scan();
    lit_check("pre_erase_px20", int'(seen[20]), 'h11);
    swap();
    swap();
    scan();
    lit_check("post_erase_px20", int'(seen[20]), 0);

    // Flipped readout
    HFLIP = 1'b1;
    wr(0, 7'h41, 1'b0);
    swap();
    scan();
    lit_check("hflip_last", int'(seen[255]), 'h41);
    lit_check("hflip_first", int'(seen[0]), 0);
    lit_check("hold_after_scan", int'(OBJCOL), 'h41);
    pixel(1'b0);
    lit_check("blank_strobe", int'(OBJCOL), 0);

    // Swap while a write is being checked
    HFLIP = 1'b0;
    wr(3, 7'h22, 1'b1);
    scan();
    lit_check("swap_in_chk_px3", int'(seen[3]), 'h22);

    @(posedge clk); #1;
    chk_en = 1'b0;
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
